hazard_sequencer: RTL and testbench
===================================

# hazard_sequencer

Pipeline control block for the five-stage MIPS core. It watches register addresses and control bits across the D/E/M/W stages and produces the stall, flush and forwarding controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences multi-cycle data-memory accesses through a wait handshake with a timeout. It sits beside the datapath and drives the enable and clear inputs of every pipeline register.

## Interface
Parameters:
- MEM_TIMEOUT, 16, max consecutive wait cycles before MemErr is raised (legal range 2..255)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- RsD, RtD  in  5 each  source registers in Decode
- RsE, RtE  in  5 each  source registers in Execute
- WriteRegE, WriteRegM, WriteRegW  in  5 each  destination registers
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables
- MemtoRegE, MemtoRegM  in  1 each  load flags
- BranchD, PCSrcD, JumpD  in  1 each  branch in D, branch taken, jump
- MemReqM  in  1  data-memory access in M
- MemReadyM  in  1  memory completes this cycle
- StallF, StallD, StallE, StallM  out  1 each  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1 each  load a bubble (zero) into IF/ID, ID/EX, MEM/WB
- ForwardAE, ForwardBE  out  2 each  00 regfile, 10 ALUOutM, 01 ResultW
- ForwardAD, ForwardBD  out  1 each  branch-compare operand from ALUOutM
- MemErr  out  1  sticky memory-timeout error
- StallCnt, FlushCnt  out  CNT_W each  only present with HAZARD_PERF_CNT_EN

## Operation
- Forwarding (combinational):
  - ForwardAE = 10 if RsE≠0 & RegWriteM & WriteRegM==RsE.
  - Otherwise ForwardAE = 01 if RsE≠0 & RegWriteW & WriteRegW==RsE.
  - Otherwise ForwardAE = 00.
  - ForwardBE follows the same rules using RtE.
  - ForwardAD = RsD≠0 & RegWriteM & WriteRegM==RsD; ForwardBD the same using RtD.
- Hazard terms:
  - lwstall = MemtoRegE & (RtE==RsD | RtE==RtD).
  - brstall = BranchD & ((RegWriteE & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & (WriteRegM==RsD | WriteRegM==RtD))).
  - memwait = MemReqM & ~MemReadyM.
- FSM states: RUN, WAIT, ERR.
  - RUN → WAIT when memwait.
  - WAIT → RUN when MemReadyM.
  - WAIT → ERR when memwait persists and wait count == MEM_TIMEOUT-1.
  - ERR is terminal until reset.
- Output priority, highest first:
  - ERR state: StallF/D/E/M=1, FlushW=1, every other flush 0; MemErr=1.
  - memwait, in RUN or WAIT: StallF/D/E/M=1, FlushW=1, FlushD=0, FlushE=0. A pending branch flush is held off until the wait ends.
  - lwstall | brstall: StallF=StallD=1, FlushE=1.
  - PCSrcD | JumpD, with no stall: FlushD=1.
  - Otherwise every stall and flush is 0.
- Wait counter:
  - 8 bits, cleared in RUN.
  - Increments on each cycle spent in WAIT with memwait=1.
  - Never wraps: ERR is entered first.

## Timing
- Stall, flush and forward outputs are combinational from inputs and state, so they are valid in the same cycle as their cause.
- The memory handshake has zero added latency: MemReadyM=1 in the first cycle releases all stalls that same cycle.
- State, wait counter and MemErr are registered on the rising clk edge.
- While rst=0:
  - state=RUN, wait count=0, MemErr=0, counters=0.
  - All stall, flush and forward outputs are forced to 0.
- Deasserting rst in the middle of a memory access resumes in RUN. The first memwait after reset is treated as a fresh wait.
- Simultaneous lwstall and a taken branch: the stall wins and FlushD=0 that cycle. The branch re-resolves after the stall.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments on every cycle with StallF=1.
  - FlushCnt increments on every cycle with FlushD|FlushE=1.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: the StallCnt and FlushCnt ports and their logic are absent.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, WAIT, ERR);
  - forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- One sub-module, forward_unit, holds the combinational E-stage and D-stage forwarding comparators. The FSM, stall/flush priority logic and counters stay in the top level.

## Test plan
- RegWriteM=1, WriteRegM=5, RsE=5, RegWriteW=1, WriteRegW=5 → ForwardAE=10 (M beats W); with RsE=0 → ForwardAE=00.
- MemtoRegE=1, RtE=8, RsD=8 → StallF=StallD=FlushE=1 for exactly one cycle, then 0 once the load moves to M.
- MemReqM=1 with MemReadyM low for 3 cycles then high → StallF..M=FlushW=1 for 3 cycles, all 0 on the 4th cycle; MemErr stays 0.
- MEM_TIMEOUT=4, MemReadyM held low → ERR entered after 4 wait cycles, MemErr=1 and stalls held; rst pulse → MemErr=0, state RUN.
- PCSrcD=1 during memwait → FlushD=0 while waiting; FlushD=1 in the first cycle after MemReadyM.
- With HAZARD_PERF_CNT_EN: 5 lwstall cycles and 2 branch flushes → StallCnt=5, FlushCnt=7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding control slice.
package pipe_ctrl_pkg;

    // Memory-access sequencing states.
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } state_e;

    // E-stage operand source selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // E-stage select for one source register; the MEM result is younger so it beats WB.
    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] src,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0 && reg_write_m && write_reg_m == src) begin
            sel = FWD_MEM;
        end else if (src != 5'd0 && reg_write_w && write_reg_w == src) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding comparators for the E-stage ALU operands and the
// D-stage branch-compare operands.
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] write_reg_m_i,
    input  logic [4:0] write_reg_w_i,
    input  logic       reg_write_m_i,
    input  logic       reg_write_w_i,
    output logic [1:0] forward_ae_o,
    output logic [1:0] forward_be_o,
    output logic       forward_ad_o,
    output logic       forward_bd_o
);

    // Operand bypass selects; register 0 is never forwarded.
    always_comb begin
        forward_ae_o = fwd_e_sel(rs_e_i, reg_write_m_i, write_reg_m_i,
                                 reg_write_w_i, write_reg_w_i);
        forward_be_o = fwd_e_sel(rt_e_i, reg_write_m_i, write_reg_m_i,
                                 reg_write_w_i, write_reg_w_i);
        forward_ad_o = (rs_d_i != 5'd0) && reg_write_m_i && (write_reg_m_i == rs_d_i);
        forward_bd_o = (rt_d_i != 5'd0) && reg_write_m_i && (write_reg_m_i == rt_d_i);
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush/forward control with a timed data-memory wait handshake.
// Optional saturating perf counters (StallCnt/FlushCnt) under HAZARD_PERF_CNT_EN.
module hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RsE,
    input  logic [4:0]       RtE,
    input  logic [4:0]       WriteRegE,
    input  logic [4:0]       WriteRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             MemtoRegM,
    input  logic             BranchD,
    input  logic             PCSrcD,
    input  logic             JumpD,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             MemErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
`endif
);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W == 0) begin : g_param_check
        $error("hazard_sequencer: MEM_TIMEOUT must be 2..255 and CNT_W nonzero");
    end

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    logic       lwstall, brstall, memwait;
    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] fwd_ae, fwd_be;
    logic       fwd_ad, fwd_bd;

    assign memwait = MemReqM & ~MemReadyM;
    assign lwstall = MemtoRegE & ((RtE == RsD) | (RtE == RtD));
    assign brstall = BranchD & ((RegWriteE & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
                                (MemtoRegM & ((WriteRegM == RsD) | (WriteRegM == RtD))));

    forward_unit u_forward_unit (
        .rs_d_i        (RsD),
        .rt_d_i        (RtD),
        .rs_e_i        (RsE),
        .rt_e_i        (RtE),
        .write_reg_m_i (WriteRegM),
        .write_reg_w_i (WriteRegW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .forward_ae_o  (fwd_ae),
        .forward_be_o  (fwd_be),
        .forward_ad_o  (fwd_ad),
        .forward_bd_o  (fwd_bd)
    );

    // Wait sequencing: count stalled WAIT cycles and trip to ERR before the counter can wrap.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (memwait) state_d = WAIT;
            end
            WAIT: begin
                if (MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (memwait) begin
                    if (wait_cnt_q == WaitLast) state_d = ERR;
                    else                        wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ERR: ;
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        mem_err_d = mem_err_q | (state_d == ERR);
    end

    // State, wait counter and sticky error register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Stall/flush priority: error or memory wait freezes everything, then load/branch stalls,
    // then control-transfer flush. A taken branch is held off while any stall is active.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (state_q == ERR || memwait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (lwstall || brstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (PCSrcD || JumpD) begin
            flush_d = 1'b1;
        end
    end

    // Every control output is held quiet while reset is asserted.
    assign StallF    = rst & stall_f;
    assign StallD    = rst & stall_d;
    assign StallE    = rst & stall_e;
    assign StallM    = rst & stall_m;
    assign FlushD    = rst & flush_d;
    assign FlushE    = rst & flush_e;
    assign FlushW    = rst & flush_w;
    assign ForwardAE = rst ? fwd_ae : FWD_RF;
    assign ForwardBE = rst ? fwd_be : FWD_RF;
    assign ForwardAD = rst & fwd_ad;
    assign ForwardBD = rst & fwd_bd;
    assign MemErr    = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters; ungated terms are fine since reset clears the counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((flush_d || flush_e) && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    // Perf counters not built.
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios plus randomized traffic
// against a behavioural model. Counter checks compile in with HAZARD_PERF_CNT_EN.
module tb_hazard_sequencer;

    localparam int unsigned MemTimeout = 4;
    localparam int unsigned CntW       = 32;

    logic       clk, rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w, memto_reg_e, memto_reg_m;
    logic       branch_d, pc_src_d, jump_d, mem_req_m, mem_ready_m;
    logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0] forward_ae, forward_be;
    logic       forward_ad, forward_bd, mem_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [CntW-1:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit         m_err, m_pending;
    int         m_wait_cycles;
    longint     m_stall_cnt, m_flush_cnt;
    logic [3:0] e_stall;
    logic [2:0] e_flush;
    logic [1:0] e_fae, e_fbe;
    logic       e_fad, e_fbd;

    hazard_sequencer #(
        .MEM_TIMEOUT (MemTimeout),
        .CNT_W       (CntW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RsD       (rs_d),
        .RtD       (rt_d),
        .RsE       (rs_e),
        .RtE       (rt_e),
        .WriteRegE (write_reg_e),
        .WriteRegM (write_reg_m),
        .WriteRegW (write_reg_w),
        .RegWriteE (reg_write_e),
        .RegWriteM (reg_write_m),
        .RegWriteW (reg_write_w),
        .MemtoRegE (memto_reg_e),
        .MemtoRegM (memto_reg_m),
        .BranchD   (branch_d),
        .PCSrcD    (pc_src_d),
        .JumpD     (jump_d),
        .MemReqM   (mem_req_m),
        .MemReadyM (mem_ready_m),
        .StallF    (stall_f),
        .StallD    (stall_d),
        .StallE    (stall_e),
        .StallM    (stall_m),
        .FlushD    (flush_d),
        .FlushE    (flush_e),
        .FlushW    (flush_w),
        .ForwardAE (forward_ae),
        .ForwardBE (forward_be),
        .ForwardAD (forward_ad),
        .ForwardBD (forward_bd),
        .MemErr    (mem_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCnt  (stall_cnt),
        .FlushCnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd_e(input logic [4:0] r);
        if (r != 0 && reg_write_m && write_reg_m == r) return 2'b10;
        if (r != 0 && reg_write_w && write_reg_w == r) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_err         = 1'b0;
        m_pending     = 1'b0;
        m_wait_cycles = 0;
        m_stall_cnt   = 0;
        m_flush_cnt   = 0;
    endtask

    // Expected outputs from the current inputs and model state.
    task automatic predict();
        bit memwait, lw, br;
        memwait = mem_req_m && !mem_ready_m;
        lw = memto_reg_e && (rt_e == rs_d || rt_e == rt_d);
        br = branch_d && ((reg_write_e && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                          (memto_reg_m && (write_reg_m == rs_d || write_reg_m == rt_d)));
        e_stall = 4'b0000;
        e_flush = 3'b000;
        e_fae   = ref_fwd_e(rs_e);
        e_fbe   = ref_fwd_e(rt_e);
        e_fad   = (rs_d != 0) && reg_write_m && (write_reg_m == rs_d);
        e_fbd   = (rt_d != 0) && reg_write_m && (write_reg_m == rt_d);
        if (!rst) begin
            e_fae = 2'b00; e_fbe = 2'b00; e_fad = 1'b0; e_fbd = 1'b0;
        end else if (m_err || memwait) begin
            e_stall = 4'b1111; e_flush = 3'b001;
        end else if (lw || br) begin
            e_stall = 4'b1100; e_flush = 3'b010;
        end else if (pc_src_d || jump_d) begin
            e_flush = 3'b100;
        end
    endtask

    // Clock-edge update: ERR after MemTimeout stalled cycles spent waiting.
    task automatic model_clock();
        bit memwait;
        memwait = mem_req_m && !mem_ready_m;
        if (e_stall[3]) m_stall_cnt++;
        if (e_flush[2] || e_flush[1]) m_flush_cnt++;
        if (m_err) return;
        if (!m_pending) begin
            if (memwait) begin
                m_pending     = 1'b1;
                m_wait_cycles = 0;
            end
        end else if (mem_ready_m) begin
            m_pending = 1'b0;
        end else if (memwait) begin
            m_wait_cycles++;
            if (m_wait_cycles == int'(MemTimeout)) m_err = 1'b1;
        end
    endtask

    // One cycle: check outputs mid-cycle, then advance model on the edge.
    task automatic step();
        if (!rst) model_reset();
        @(negedge clk);
        predict();
        check("stall", {stall_f, stall_d, stall_e, stall_m}, e_stall);
        check("flush", {flush_d, flush_e, flush_w}, e_flush);
        check("fwd", {forward_ae, forward_be, forward_ad, forward_bd}, {e_fae, e_fbe, e_fad, e_fbd});
        check("memerr", mem_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, m_stall_cnt[31:0]);
        check("flush_cnt", flush_cnt, m_flush_cnt[31:0]);
`endif
        @(posedge clk);
        if (rst) model_clock();
        #1;
    endtask

    task automatic idle();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        memto_reg_e = 0; memto_reg_m = 0;
        branch_d = 0; pc_src_d = 0; jump_d = 0;
        mem_req_m = 0; mem_ready_m = 0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        // Reset values, with a hazard pattern present to prove forcing
        reg_write_m = 1; write_reg_m = 5; rs_e = 5; mem_req_m = 1;
        step();
        step();
        idle();
        rst = 1'b1;

        // Perf counters: 5 load-use stalls, then 2 branch flushes
        memto_reg_e = 1; rt_e = 8; rs_d = 8;
        repeat (5) step();
        idle();
        pc_src_d = 1;
        repeat (2) step();
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall", stall_cnt, 5);
        check("perf_flush", flush_cnt, 7);
`endif
        idle();

        // Forwarding priority and register 0
        reg_write_m = 1; write_reg_m = 5; rs_e = 5; reg_write_w = 1; write_reg_w = 5;
        #1 check("fwd_m_over_w", forward_ae, 2'b10);
        step();
        rs_e = 0;
        #1 check("fwd_r0", forward_ae, 2'b00);
        step();
        rs_e = 5; reg_write_m = 0; rt_e = 5;
        #1 check("fwd_wb", {forward_ae, forward_be}, 4'b0101);
        step();
        idle();

        // Load-use stall, released once the load reaches M
        memto_reg_e = 1; rt_e = 8; rs_d = 8;
        #1 check("lw_stall", {stall_f, stall_d, flush_e}, 3'b111);
        step();
        memto_reg_e = 0; memto_reg_m = 1; reg_write_m = 1; write_reg_m = 8;
        #1 check("lw_release", {stall_f, stall_d, flush_e}, 3'b000);
        check("fwd_ad", forward_ad, 1'b1);
        step();
        idle();

        // Three-cycle memory wait
        mem_req_m = 1; mem_ready_m = 0;
        repeat (3) begin
            #1 check("memwait_stall", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'b11111);
            step();
        end
        mem_ready_m = 1;
        #1 check("memwait_release", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'b00000);
        check("memwait_no_err", mem_err, 1'b0);
        step();
        idle();

        // Taken branch held off during a memory wait
        mem_req_m = 1; pc_src_d = 1;
        repeat (2) begin
            #1 check("br_held", flush_d, 1'b0);
            step();
        end
        mem_ready_m = 1;
        #1 check("br_after_wait", flush_d, 1'b1);
        step();
        idle();

        // Load-use stall beats a taken branch
        memto_reg_e = 1; rt_e = 3; rt_d = 3; pc_src_d = 1;
        #1 check("lw_beats_br", {stall_f, flush_d}, 2'b10);
        step();
        idle();

        // Branch operand hazard against an E-stage writer
        branch_d = 1; reg_write_e = 1; write_reg_e = 7; rs_d = 7;
        #1 check("br_stall", {stall_f, stall_d, flush_e, flush_d}, 4'b1110);
        step();
        idle();

        // Timeout into ERR, then reset recovery
        mem_req_m = 1;
        repeat (5) begin
            #1 check("to_no_err", mem_err, 1'b0);
            step();
        end
        #1 check("to_err", mem_err, 1'b1);
        mem_ready_m = 1;
        #1 check("err_holds", {stall_f, stall_d, stall_e, stall_m, flush_w}, 5'b11111);
        step();
        rst = 1'b0;
        #1 check("rst_clears_err", mem_err, 1'b0);
        step();
        rst = 1'b1;
        idle();
        step();

        // Reset in mid-wait restarts the wait count from scratch
        mem_req_m = 1;
        repeat (3) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        repeat (4) step();
        #1 check("fresh_wait_no_err", mem_err, 1'b0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 39) != 0);
            rs_d        = 5'($urandom_range(0, 3));
            rt_d        = 5'($urandom_range(0, 3));
            rs_e        = 5'($urandom_range(0, 3));
            rt_e        = 5'($urandom_range(0, 3));
            write_reg_e = 5'($urandom_range(0, 3));
            write_reg_m = 5'($urandom_range(0, 3));
            write_reg_w = 5'($urandom_range(0, 3));
            reg_write_e = 1'($urandom_range(0, 1));
            reg_write_m = 1'($urandom_range(0, 1));
            reg_write_w = 1'($urandom_range(0, 1));
            memto_reg_e = ($urandom_range(0, 3) == 0);
            memto_reg_m = ($urandom_range(0, 3) == 0);
            branch_d    = ($urandom_range(0, 3) == 0);
            pc_src_d    = ($urandom_range(0, 3) == 0);
            jump_d      = ($urandom_range(0, 7) == 0);
            mem_req_m   = ($urandom_range(0, 2) == 0);
            mem_ready_m = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
